// File: rtl/sdf_pulse_stim_gen_pkg.sv
// sdf_stim_pkg: shared types and helpers for the SDF pulse stimulus generator.
//   state_t    : controller states
//   pat_t      : decoded pattern fields (sel, pulse target, baseline, width)
//   pat_decode : pattern index -> pat_t
//   exp_q      : expected registered netlist outputs {q1, q2} for given inputs
package sdf_stim_pkg;

  localparam int unsigned IDX_W = 4;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    PULSE,
    HOLD,
    CHECK,
    DONE
  } state_t;

  typedef struct packed {
    logic       sel;
    logic       target;  // 0: pulse d1, 1: pulse d2
    logic       base;    // level of d1/d2 outside the pulse
    logic [3:0] w;       // pulse width in cycles, 1..8
  } pat_t;

  function automatic pat_t pat_decode(input logic [IDX_W-1:0] idx,
                                      input int unsigned wmax);
    pat_t p;
    p.sel    = idx[0];
    p.target = idx[1];
    p.base   = idx[2];
    p.w      = 4'((32'(idx) % wmax) + 32'd1);
    return p;
  endfunction

  // Netlist function: n4 = ~d2 | (d1 & sel); q1 = n4; q2 = ~(n4 & sel).
  function automatic logic [1:0] exp_q(input logic d1, input logic d2,
                                       input logic sel);
    logic n4;
    n4 = ~d2 | (d1 & sel);
    return {n4, ~(n4 & sel)};
  endfunction

endpackage

// File: rtl/sdf_pulse_stim_gen_if.sv
// sdf_pulse_stim_gen_if: bus between the stimulus generator and the timing netlist.
//   d1, d2, sel : generator -> netlist data/condition inputs
//   q1, q2      : netlist -> generator registered outputs
//   master      : generator side; slave : netlist side
interface sdf_pulse_stim_gen_if;
  logic d1;
  logic d2;
  logic sel;
  logic q1;
  logic q2;

  modport master (output d1, output d2, output sel, input q1, input q2);
  modport slave  (input d1, input d2, input sel, output q1, output q2);
endinterface

// File: rtl/sdf_pulse_stim_gen_timer.sv
// sdf_stim_timer: loadable down-counter with a zero flag, shared by the
// pulse-width and settle phases.
//   clk, rst_n : clock, asynchronous active-low reset
//   load       : load load_val (takes priority over dec)
//   load_val   : value to load
//   dec        : decrement by one
//   zero       : count is zero
module sdf_stim_timer #(
  parameter int unsigned TW = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load,
  input  logic [TW-1:0] load_val,
  input  logic          dec,
  output logic          zero
);

  logic [TW-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (dec && (cnt != '0)) begin
      cnt <= cnt - TW'(1);
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/sdf_pulse_stim_gen.sv
// sdf_pulse_stim_gen: drives pulses of programmed width onto the conditional /
// path-pulse SDF netlist and checks its registered outputs after settling.
//   clk, rst_n : rising-edge clock, asynchronous active-low reset
//   start      : 1-cycle pulse, begins a run when idle
//   dut        : master side of the netlist bus (d1/d2/sel out, q1/q2 in)
//   busy       : high from start accept until DONE
//   done       : 1-cycle pulse at end of run
//   pat_idx    : current pattern index
//   mismatch   : 1-cycle pulse on a failed check
//   err_cnt    : saturating mismatch count, cleared on start accept
module sdf_pulse_stim_gen
  import sdf_stim_pkg::*;
#(
  parameter int unsigned NUM_PAT    = 8,
  parameter int unsigned PULSE_WMAX = 4,
  parameter int unsigned GAP        = 2,
  parameter int unsigned ERR_W      = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  sdf_pulse_stim_gen_if.master dut,
  output logic                 busy,
  output logic                 done,
  output logic [IDX_W-1:0]     pat_idx,
  output logic                 mismatch,
  output logic [ERR_W-1:0]     err_cnt
);

  localparam int unsigned      TW       = 16;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_PAT - 1);

  state_t           state, state_n;
  logic [IDX_W-1:0] idx_n;
  pat_t             pat_nx;
  logic             d1_q, d2_q, sel_q;
  logic             d1_n, d2_n, sel_n;
  logic             tmr_load, tmr_dec, tmr_zero;
  logic [TW-1:0]    tmr_val;

  sdf_stim_timer #(.TW(TW)) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (tmr_load),
    .load_val (tmr_val),
    .dec      (tmr_dec),
    .zero     (tmr_zero)
  );

  // Pattern for the index that will be current after this edge.
  assign pat_nx = pat_decode(idx_n, PULSE_WMAX);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      pat_idx <= '0;
      d1_q    <= 1'b0;
      d2_q    <= 1'b0;
      sel_q   <= 1'b0;
    end else begin
      state   <= state_n;
      pat_idx <= idx_n;
      d1_q    <= d1_n;
      d2_q    <= d2_n;
      sel_q   <= sel_n;
    end
  end

  always_comb begin
    state_n  = state;
    idx_n    = pat_idx;
    tmr_load = 1'b0;
    tmr_val  = '0;
    tmr_dec  = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_n = SETUP;
          idx_n   = '0;
        end
      end
      SETUP: begin
        // Timer holds W-1 during the first PULSE cycle, so PULSE lasts W cycles.
        state_n  = PULSE;
        tmr_load = 1'b1;
        tmr_val  = TW'(pat_nx.w) - TW'(1);
      end
      PULSE: begin
        if (tmr_zero) begin
          state_n  = HOLD;
          tmr_load = 1'b1;
          tmr_val  = TW'(GAP - 1);
        end else begin
          tmr_dec = 1'b1;
        end
      end
      HOLD: begin
        if (tmr_zero) begin
          state_n = CHECK;
        end else begin
          tmr_dec = 1'b1;
        end
      end
      CHECK: begin
        if (pat_idx == LAST_IDX) begin
          state_n = DONE;
        end else begin
          state_n = SETUP;
          idx_n   = pat_idx + IDX_W'(1);
        end
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Stimulus flops are loaded from the next state and next pattern, so each
  // pulse edge lands exactly on the clock edge entering/leaving PULSE.
  always_comb begin
    d1_n  = d1_q;
    d2_n  = d2_q;
    sel_n = sel_q;
    case (state_n)
      SETUP, HOLD, CHECK: begin
        sel_n = pat_nx.sel;
        d1_n  = pat_nx.base;
        d2_n  = pat_nx.base;
      end
      PULSE: begin
        sel_n = pat_nx.sel;
        d1_n  = pat_nx.target ? pat_nx.base : ~pat_nx.base;
        d2_n  = pat_nx.target ? ~pat_nx.base : pat_nx.base;
      end
      default: ;
    endcase
  end

  assign dut.d1  = d1_q;
  assign dut.d2  = d2_q;
  assign dut.sel = sel_q;

  // In CHECK the stimulus flops hold the baseline, so they give the expectation.
  assign mismatch = (state == CHECK) &&
                    ({dut.q1, dut.q2} != exp_q(d1_q, d2_q, sel_q));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt <= '0;
    end else if ((state == IDLE) && start) begin
      err_cnt <= '0;
    end else if (mismatch && (err_cnt != '1)) begin
      err_cnt <= err_cnt + ERR_W'(1);
    end
  end

  assign busy = (state != IDLE) && (state != DONE);
  assign done = (state == DONE);

endmodule

// File: tb/tb_sdf_pulse_stim_gen.sv
// Directed bench for sdf_pulse_stim_gen with a behavioural model of the
// registered netlist (plus fault controls) on each generator's bus.
module tb_sdf_pulse_stim_gen;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start_a = 1'b0;
  logic start_b = 1'b0;
  logic q2_stuck = 1'b0;

  always #5 clk = ~clk;

  sdf_pulse_stim_gen_if bus_a ();
  sdf_pulse_stim_gen_if bus_b ();

  logic       busy_a, done_a, mm_a, busy_b, done_b, mm_b;
  logic [3:0] idx_a, idx_b;
  logic [7:0] err_a;
  logic [1:0] err_b;

  sdf_pulse_stim_gen #(.NUM_PAT(8), .PULSE_WMAX(4), .GAP(2), .ERR_W(8)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .start(start_a), .dut(bus_a.master),
    .busy(busy_a), .done(done_a), .pat_idx(idx_a), .mismatch(mm_a), .err_cnt(err_a)
  );

  sdf_pulse_stim_gen #(.NUM_PAT(8), .PULSE_WMAX(4), .GAP(2), .ERR_W(2)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .dut(bus_b.master),
    .busy(busy_b), .done(done_b), .pat_idx(idx_b), .mismatch(mm_b), .err_cnt(err_b)
  );

  // Netlist models: q1 = DFF(n4), q2 = DFF(~(n4 & sel)), n4 = ~d2 | (d1 & sel)
  logic qa1, qa2, qb1, qb2;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      qa1 <= 1'b0; qa2 <= 1'b0; qb1 <= 1'b0; qb2 <= 1'b0;
    end else begin
      qa1 <= ~bus_a.d2 | (bus_a.d1 & bus_a.sel);
      qa2 <= ~((~bus_a.d2 | (bus_a.d1 & bus_a.sel)) & bus_a.sel);
      qb1 <= ~bus_b.d2 | (bus_b.d1 & bus_b.sel);
      qb2 <= ~((~bus_b.d2 | (bus_b.d1 & bus_b.sel)) & bus_b.sel);
    end
  end
  assign bus_a.q1 = qa1;
  assign bus_a.q2 = q2_stuck ? 1'b1 : qa2;
  assign bus_b.q1 = ~qb1;  // q1 inverted on every pattern
  assign bus_b.q2 = qb2;

  // Per-run observations, restarted whenever busy rises.
  int unsigned mmc_a = 0, mmc_b = 0, done_n_a = 0;
  int unsigned d1lo5 = 0, d2lo5 = 0, sello5 = 0;
  logic [15:0] mask_a = '0;
  logic [1:0]  q5 = '0;
  logic        lb_a = 1'b0, lb_b = 1'b0;
  logic [3:0]  seq_a[$];

  always @(negedge clk) begin
    if (busy_a && !lb_a) begin
      mmc_a = 0; mask_a = '0; seq_a.delete(); seq_a.push_back(idx_a);
      d1lo5 = 0; d2lo5 = 0; sello5 = 0;
    end else if (busy_a && (seq_a.size() > 0) && (idx_a != seq_a[$])) begin
      seq_a.push_back(idx_a);
    end
    if (mm_a) begin mmc_a++; mask_a[idx_a] = 1'b1; end
    if (busy_a && (idx_a == 4'd5)) begin
      if (!bus_a.d1)  d1lo5++;
      if (!bus_a.d2)  d2lo5++;
      if (!bus_a.sel) sello5++;
      q5 = {bus_a.q1, bus_a.q2};
    end
    if (done_a) done_n_a++;
    lb_a = busy_a;
    if (busy_b && !lb_b) mmc_b = 0;
    if (mm_b) mmc_b++;
    lb_b = busy_b;
  end

  int unsigned n_vec = 0, n_err = 0;

  task automatic chk(input string tag, input int unsigned got, input int unsigned exp);
    n_vec++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Starts a run on DUT A and returns at the negedge where done is seen.
  task automatic run_a(input bit spam, output int unsigned cyc);
    bit got;
    got = 1'b0;
    cyc = 0;
    @(negedge clk) start_a = 1'b1;
    @(posedge clk);
    #1 start_a = 1'b0;
    for (int k = 0; k < 200; k++) begin
      @(posedge clk);
      cyc++;
      @(negedge clk);
      start_a = spam && ((cyc == 10) || (cyc == 31));
      if (done_a) begin got = 1'b1; break; end
    end
    start_a = 1'b0;
    if (!got) chk("run_a_timeout", 0, 1);
  endtask

  task automatic chk_seq(input string tag);
    chk({tag, "_len"}, seq_a.size(), 8);
    for (int i = 0; i < 8; i++)
      if (i < seq_a.size()) chk(tag, seq_a[i], i);
  endtask

  initial begin
    int unsigned cyc, dn0;
    bit found;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_d1", bus_a.d1, 0);
    chk("rst_d2", bus_a.d2, 0);
    chk("rst_sel", bus_a.sel, 0);
    chk("rst_busy", busy_a, 0);
    chk("rst_done", done_a, 0);
    chk("rst_idx", idx_a, 0);
    chk("rst_mm", mm_a, 0);
    chk("rst_err", err_a, 0);
    rst_n = 1'b1;

    // Async reset in the middle of idx 3 PULSE (d2 pulsed high from base 0)
    q2_stuck = 1'b1;
    @(negedge clk) start_a = 1'b1;
    @(posedge clk);
    #1 start_a = 1'b0;
    found = 1'b0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if ((idx_a == 4'd3) && bus_a.d2) begin found = 1'b1; break; end
    end
    chk("pulse3_found", found, 1);
    chk("pre_rst_err", err_a, 1);
    dn0 = done_n_a;
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_d1", bus_a.d1, 0);
    chk("midrst_d2", bus_a.d2, 0);
    chk("midrst_sel", bus_a.sel, 0);
    chk("midrst_busy", busy_a, 0);
    chk("midrst_err", err_a, 0);
    @(negedge clk) rst_n = 1'b1;
    q2_stuck = 1'b0;
    repeat (3) @(negedge clk);
    chk("postrst_busy", busy_a, 0);
    chk("postrst_idx", idx_a, 0);
    chk("postrst_no_done", done_n_a - dn0, 0);

    // Clean run: latency, error-free, idx 5 waveform
    run_a(1'b0, cyc);
    chk("clean_cycles", cyc, 52);
    chk("clean_err", err_a, 0);
    chk("clean_mm", mmc_a, 0);
    chk("clean_idx_done", idx_a, 7);
    chk("clean_busy_done", busy_a, 0);
    chk("idx5_d1_low", d1lo5, 2);
    chk("idx5_d2_low", d2lo5, 0);
    chk("idx5_sel_low", sello5, 0);
    chk("idx5_q", q5, 2'b10);
    chk_seq("clean_seq");
    @(negedge clk);
    chk("done_one_cycle", done_a, 0);
    chk("idx_held", idx_a, 7);

    // q2 stuck-at-1: fails where sel=1
    q2_stuck = 1'b1;
    run_a(1'b0, cyc);
    chk("stuck_err", err_a, 4);
    chk("stuck_mm", mmc_a, 4);
    chk("stuck_mask", mask_a, 16'h00AA);
    q2_stuck = 1'b0;
    @(negedge clk);

    // start while busy ignored; new run clears err_cnt; start during DONE ignored
    dn0 = done_n_a;
    run_a(1'b1, cyc);
    chk("spam_cycles", cyc, 52);
    chk("spam_err_cleared", err_a, 0);
    chk_seq("spam_seq");
    start_a = 1'b1;
    @(negedge clk) start_a = 1'b0;
    chk("start_at_done_busy", busy_a, 0);
    @(negedge clk);
    chk("start_at_done_busy2", busy_a, 0);
    chk("spam_done_count", done_n_a - dn0, 1);

    // ERR_W=2 with q1 inverted: saturates at 3
    @(negedge clk) start_b = 1'b1;
    @(posedge clk);
    #1 start_b = 1'b0;
    found = 1'b0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (done_b) begin found = 1'b1; break; end
    end
    chk("sat_done", found, 1);
    chk("sat_err", err_b, 3);
    chk("sat_mm", mmc_b, 8);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
